// File: rtl/alu_pkg.sv
// Shared definitions for the Hack-style ALU: datapath width, control word layout
// and the control encodings of the standard functions.
package alu_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;
    localparam int unsigned CTRL_W        = 6;

    // Control word in the fixed order {zx, nx, zy, ny, f, no}
    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } ctrl_t;

    localparam ctrl_t CTRL_ZERO        = ctrl_t'(6'b101010);
    localparam ctrl_t CTRL_ONE         = ctrl_t'(6'b111111);
    localparam ctrl_t CTRL_X           = ctrl_t'(6'b001100);
    localparam ctrl_t CTRL_X_PLUS_Y    = ctrl_t'(6'b000010);
    localparam ctrl_t CTRL_X_MINUS_Y   = ctrl_t'(6'b010011);
    localparam ctrl_t CTRL_X_AND_Y     = ctrl_t'(6'b000000);
    localparam ctrl_t CTRL_X_OR_Y      = ctrl_t'(6'b010101);

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: operand conditioning, add/and select,
// output inversion and the zero/negative/carry flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  ctrl_t            ctrl,
    output logic [WIDTH-1:0] out_c,
    output logic             zr_c,
    output logic             ng_c,
    output logic             co_c
);

    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] x2;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] y2;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;

    // Zeroing always precedes inversion on each operand
    assign x1 = ctrl.zx ? '0 : x;
    assign x2 = ctrl.nx ? ~x1 : x1;
    assign y1 = ctrl.zy ? '0 : y;
    assign y2 = ctrl.ny ? ~y1 : y1;

    assign sum = {1'b0, x2} + {1'b0, y2};
    assign r   = ctrl.f ? sum[WIDTH-1:0] : (x2 & y2);

    // Carry is taken from the raw sum, before the final inversion
    assign co_c  = ctrl.f & sum[WIDTH];
    assign out_c = ctrl.no ? ~r : r;
    assign zr_c  = ~|out_c;
    assign ng_c  = out_c[WIDTH-1];

endmodule

// File: rtl/alu.sv
// Hack-style ALU top: combinational result/flags plus a one-cycle registered copy
// that is cleared by an asynchronous active-high reset.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             co,
    output logic [WIDTH-1:0] out_q,
    output logic             zr_q,
    output logic             ng_q,
    output logic             co_q
);

    ctrl_t ctrl;

    assign ctrl = {zx, nx, zy, ny, f, no};

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .x    (x),
        .y    (y),
        .ctrl (ctrl),
        .out_c(out),
        .zr_c (zr),
        .ng_c (ng),
        .co_c (co)
    );

    // Pipelined copy for downstream consumers; free-running, no enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            zr_q  <= 1'b0;
            ng_q  <= 1'b0;
            co_q  <= 1'b0;
        end else begin
            out_q <= out;
            zr_q  <= zr;
            ng_q  <= ng;
            co_q  <= co;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, named-function checks,
// registered-path/reset sequences and a randomized sweep of all 64 control words.
module tb_alu;
    import alu_pkg::*;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         zx, nx, zy, ny, f, no;
    logic [W-1:0] out;
    logic         zr, ng, co;
    logic [W-1:0] out_q;
    logic         zr_q, ng_q, co_q;

    int tests_run = 0;
    int tests_failed = 0;

    alu #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .x    (x),
        .y    (y),
        .zx   (zx),
        .nx   (nx),
        .zy   (zy),
        .ny   (ny),
        .f    (f),
        .no   (no),
        .out  (out),
        .zr   (zr),
        .ng   (ng),
        .co   (co),
        .out_q(out_q),
        .zr_q (zr_q),
        .ng_q (ng_q),
        .co_q (co_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [5:0]   c;
        logic [W-1:0] out;
        logic         zr;
        logic         ng;
        logic         co;
    } vec_t;

    typedef struct {
        logic [W-1:0] out;
        logic         zr;
        logic         ng;
        logic         co;
    } res_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic [5:0] c);
        x = xv;
        y = yv;
        {zx, nx, zy, ny, f, no} = c;
    endtask

    // Reference written with plain integer arithmetic on the operand rules
    function automatic res_t model(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic [5:0] c);
        res_t res;
        int   mask;
        int   a;
        int   b;
        int   r;
        mask = (1 << W) - 1;
        a = c[5] ? 0 : int'(xv);
        if (c[4]) a = mask - a;
        b = c[3] ? 0 : int'(yv);
        if (c[2]) b = mask - b;
        r = c[1] ? a + b : (a & b);
        res.co = c[1] && (r > mask);
        r = r % (mask + 1);
        if (c[0]) r = mask - r;
        res.out = W'(r);
        res.zr  = (r == 0);
        res.ng  = (r >= (1 << (W - 1)));
        return res;
    endfunction

    task automatic check_comb(input string tag, input res_t e);
        check({tag, ".out"}, 32'(out), 32'(e.out));
        check({tag, ".zr"},  32'(zr),  32'(e.zr));
        check({tag, ".ng"},  32'(ng),  32'(e.ng));
        check({tag, ".co"},  32'(co),  32'(e.co));
    endtask

    task automatic check_reg(input string tag, input res_t e);
        check({tag, ".out_q"}, 32'(out_q), 32'(e.out));
        check({tag, ".zr_q"},  32'(zr_q),  32'(e.zr));
        check({tag, ".ng_q"},  32'(ng_q),  32'(e.ng));
        check({tag, ".co_q"},  32'(co_q),  32'(e.co));
    endtask

    vec_t vecs[$];
    res_t zero_res;
    res_t e;

    initial begin
        vecs.push_back('{16'h000A, 16'h0005, 6'b000010, 16'h000F, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{16'h000A, 16'h0005, 6'b000000, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{16'h000A, 16'h0005, 6'b100010, 16'h0005, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{16'h000A, 16'h0005, 6'b001010, 16'h000A, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{16'h000A, 16'h0005, 6'b110001, 16'hFFFA, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{16'h7FFF, 16'h0001, 6'b000010, 16'h8000, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0001, 6'b000010, 16'h0000, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{16'h000A, 16'h0005, 6'b101010, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{16'h000A, 16'h0005, 6'b111111, 16'h0001, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{16'h000A, 16'h0005, 6'b010011, 16'h0005, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{16'h000A, 16'h0005, 6'b010101, 16'h000F, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{16'h1234, 16'h5678, 6'b001100, 16'h1234, 1'b0, 1'b0, 1'b0});

        zero_res = '{16'h0000, 1'b0, 1'b0, 1'b0};

        // Reset state, with the combinational path live during reset
        rst = 1'b0;
        drive(16'h000A, 16'h0005, 6'b000010);
        #1 rst = 1'b1;
        #2;
        check_reg("reset", zero_res);
        check("reset.comb_out", 32'(out), 32'h000F);
        @(posedge clk); #1;
        check_reg("reset_held", zero_res);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reg("post_release_no_edge", zero_res);

        // Directed table
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].x, vecs[i].y, vecs[i].c);
            #1;
            e = '{vecs[i].out, vecs[i].zr, vecs[i].ng, vecs[i].co};
            check_comb($sformatf("vec%0d", i), e);
            @(posedge clk); #1;
            check_reg($sformatf("vec%0d", i), e);
        end

        // Standard functions on random operands, expectations from their arithmetic meaning
        for (int k = 0; k < 20; k++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
            drive(a, b, CTRL_ZERO);      #1; check("std.zero",  32'(out), 32'h0);
            drive(a, b, CTRL_ONE);       #1; check("std.one",   32'(out), 32'h1);
            drive(a, b, CTRL_X);         #1; check("std.x",     32'(out), 32'(a));
            drive(a, b, CTRL_X_PLUS_Y);  #1; check("std.add",   32'(out), 32'(W'(a + b)));
            drive(a, b, CTRL_X_MINUS_Y); #1; check("std.sub",   32'(out), 32'(W'(a - b)));
            drive(a, b, CTRL_X_AND_Y);   #1; check("std.and",   32'(out), 32'(a & b));
            drive(a, b, CTRL_X_OR_Y);    #1; check("std.or",    32'(out), 32'(a | b));
        end

        // Registered path: capture x+y=15, then async reset between edges
        @(negedge clk);
        drive(16'h000A, 16'h0005, 6'b000010);
        @(posedge clk); #1;
        check("regpath.out_q", 32'(out_q), 32'h000F);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check_reg("midcycle_reset", zero_res);
        check("midcycle_reset.comb_out", 32'(out), 32'h000F);
        @(posedge clk); #1;
        check_reg("midcycle_reset_held", zero_res);
        @(negedge clk);
        rst = 1'b0;
        drive(16'hFFFF, 16'h0001, 6'b000010);
        @(posedge clk); #1;
        check_reg("first_capture", '{16'h0000, 1'b1, 1'b0, 1'b1});

        // All 64 control words on random operands against the reference model
        for (int rep = 0; rep < 4; rep++) begin
            for (int c = 0; c < 64; c++) begin
                logic [W-1:0] a;
                logic [W-1:0] b;
                a = W'($urandom);
                b = W'($urandom);
                if (rep == 0) a = 16'hFFFF;
                @(negedge clk);
                drive(a, b, 6'(c));
                #1;
                e = model(a, b, 6'(c));
                check_comb($sformatf("sweep_c%0d", c), e);
                @(posedge clk); #1;
                check_reg($sformatf("sweep_c%0d", c), e);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
